// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer -- prescaled down-counter with a one-shot or periodic reload and a
// level interrupt.
//
// Ports
//   clk       : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   reg_we    : full-word register write strobe
//   reg_addr  : register word index (0 CTRL, 1 PRESCALE, 2 RELOAD, 3 COUNT,
//               4 STATUS, 5-7 unmapped)
//   reg_data  : write data
//   reg_q     : registered read data for the register at reg_addr
//   irq       : EXPIRED & IRQ_EN
//
// Bus timing: there is no valid/ready handshake. A write takes effect on the
// rising edge where reg_we=1. Every edge samples reg_addr, and reg_q shows that
// register's pre-edge value one cycle later. Reads have no side effects.
// -----------------------------------------------------------------------------
module timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_we,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [31:0] reg_q,
    output logic        irq
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_RELOAD   = 3'd2;
    localparam logic [2:0] ADDR_COUNT    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    // ctrl_q: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN
    logic [2:0]            ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           reload_q,   reload_d;
    logic [31:0]           count_q,    count_d;
    logic                  expired_q,  expired_d;
    logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
    logic [31:0]           reg_d;

    logic wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic tick, expire;

    assign wr_ctrl     = reg_we && (reg_addr == ADDR_CTRL);
    assign wr_prescale = reg_we && (reg_addr == ADDR_PRESCALE);
    assign wr_reload   = reg_we && (reg_addr == ADDR_RELOAD);
    assign wr_count    = reg_we && (reg_addr == ADDR_COUNT);
    assign wr_status   = reg_we && (reg_addr == ADDR_STATUS);

    // One tick per PRESCALE+1 enabled cycles.
    assign tick   = ctrl_q[0] && (pcnt_q == prescale_q);
    // A software COUNT write in the same cycle suppresses the expiry.
    assign expire = tick && (count_q == 32'd0) && !wr_count;

    assign irq = expired_q & ctrl_q[2];

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        expired_d  = expired_q;
        pcnt_d     = pcnt_q;
        reg_d      = 32'd0;

        // Prescaler: restarts on reconfiguration, idles at 0 while disabled.
        if (wr_ctrl || wr_prescale || !ctrl_q[0] || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end

        // COUNT: software write beats decrement and reload.
        if (wr_count) begin
            count_d = reg_data;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q[1]) begin
                count_d = reload_q;
            end
        end

        // EXPIRED: W1C, but a same-cycle expiry wins.
        if (wr_status && reg_data[0]) begin
            expired_d = 1'b0;
        end
        if (expire) begin
            expired_d = 1'b1;
        end

        // One-shot expiry drops EN unless software rewrites CTRL this cycle.
        if (expire && !ctrl_q[1]) begin
            ctrl_d[0] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = reg_data[2:0];
        end

        if (wr_prescale) begin
            prescale_d = reg_data[PRESCALE_W-1:0];
        end
        if (wr_reload) begin
            reload_d = reg_data;
        end

        // Read mux sees pre-edge register values.
        case (reg_addr)
            ADDR_CTRL:     reg_d[2:0] = ctrl_q;
            ADDR_PRESCALE: reg_d[PRESCALE_W-1:0] = prescale_q;
            ADDR_RELOAD:   reg_d = reload_q;
            ADDR_COUNT:    reg_d = count_q;
            ADDR_STATUS:   reg_d[0] = expired_q;
            default:       reg_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
            pcnt_q     <= '0;
            reg_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            pcnt_q     <= pcnt_d;
            reg_q      <= reg_d;
        end
    end

endmodule

// File: tb/tb_timer.sv
module tb_timer;

  localparam int PW = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] reg_q;
  logic        irq;

  always #5 clk = ~clk;

  timer #(.PRESCALE_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .reg_q    (reg_q),
    .irq      (irq)
  );

  // ---------------- counters / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];   // {irq, reg_q}
  string       tag_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]    m_ctrl;
  logic [PW-1:0] m_pre;
  logic [31:0]   m_reload;
  logic [31:0]   m_count;
  logic          m_exp;
  logic [PW-1:0] m_phase;   // enabled cycles since the prescaler last restarted

  function automatic void m_reset();
    m_ctrl = '0; m_pre = '0; m_reload = '0; m_count = '0; m_exp = 1'b0; m_phase = '0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return {16'd0, m_pre};
      3'd2:    return m_reload;
      3'd3:    return m_count;
      3'd4:    return {31'd0, m_exp};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one rising edge with the given bus input.
  function automatic void m_step(input logic we, input logic [2:0] a, input logic [31:0] d);
    bit en, periodic, tick, sw_count, expiry;
    en       = m_ctrl[0];
    periodic = m_ctrl[1];
    tick     = en && (m_phase == m_pre);
    sw_count = we && (a == 3'd3);
    expiry   = tick && (m_count == 0) && !sw_count;

    if ((we && (a == 3'd0 || a == 3'd1)) || !en || tick) m_phase = '0;
    else m_phase = m_phase + 1;

    if (sw_count)             m_count = d;
    else if (tick && m_count != 0) m_count = m_count - 1;
    else if (expiry && periodic)   m_count = m_reload;

    if (we && a == 3'd4 && d[0]) m_exp = 1'b0;
    if (expiry) m_exp = 1'b1;

    if (expiry && !periodic) m_ctrl[0] = 1'b0;
    if (we && a == 3'd0) m_ctrl = d[2:0];
    if (we && a == 3'd1) m_pre = d[PW-1:0];
    if (we && a == 3'd2) m_reload = d;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives one bus cycle and returns at the next falling edge.
  task automatic issue(input logic we, input logic [2:0] a, input logic [31:0] d,
                       input bit use_c, input logic [31:0] c, input string tag);
    logic [31:0] rd;
    reg_we = we; reg_addr = a; reg_data = d;
    rd = use_c ? c : m_read(a);
    m_step(we, a, d);
    exp_q.push_back({m_exp & m_ctrl[2], rd});
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    issue(1'b1, a, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [2:0] a);
    issue(1'b0, a, 32'd0, 1'b0, 32'd0, "rd");
  endtask

  task automatic rdc(input logic [2:0] a, input logic [31:0] c, input string tag);
    issue(1'b0, a, 32'd0, 1'b1, c, tag);
  endtask

  // ---------------- monitor ----------------
  logic [32:0] mon_e;
  string       mon_t;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        chk({mon_t, "_rdata"}, reg_q, mon_e[31:0]);
        chk({mon_t, "_irq"}, {31'd0, irq}, {31'd0, mon_e[32]});
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  int n;
  int first_gap;

  initial begin
    rst_n = 1'b0; reg_we = 1'b0; reg_addr = 3'd0; reg_data = 32'd0;
    m_reset();
    @(negedge clk);
    chk("reset_rdata", reg_q, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) rdc(3'(a), 32'd0, "reset_reg");

    // Periodic: PRESCALE=3 RELOAD=4 COUNT=4 -> expiry every (4+1)*(3+1) cycles.
    wr(3'd1, 32'd3); wr(3'd2, 32'd4); wr(3'd3, 32'd4);
    wr(3'd0, 32'b111);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      rd(3'd4); n = i;
      if (irq) break;
    end
    chk("periodic_first", n, (4 + 1) * (3 + 1));
    rdc(3'd3, 32'd4, "periodic_reload");
    wr(3'd4, 32'd1);
    first_gap = 2;
    for (int i = 3; i <= 100; i++) begin
      rd(3'd3); first_gap = i;
      if (irq) break;
    end
    chk("periodic_second", first_gap, (4 + 1) * (3 + 1));
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);

    // One-shot: PRESCALE=0 COUNT=2 -> expiry 3 cycles after the CTRL write.
    wr(3'd1, 32'd0); wr(3'd3, 32'd2);
    wr(3'd0, 32'b101);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      rd(3'd4); n = i;
      if (irq) break;
    end
    chk("oneshot_latency", n, 3);
    rdc(3'd0, 32'b100, "oneshot_en_cleared");
    rdc(3'd3, 32'd0, "oneshot_count");
    wr(3'd4, 32'd1);
    for (int i = 0; i < 10; i++) rd(3'd3);
    rdc(3'd4, 32'd0, "oneshot_no_reexpiry");

    // W1C in the exact expiry cycle: expiry wins.
    wr(3'd3, 32'd2);
    wr(3'd0, 32'b101);
    rd(3'd4); rd(3'd4);
    wr(3'd4, 32'd1);
    rdc(3'd4, 32'd1, "w1c_vs_expiry");
    chk("w1c_vs_expiry_irq", {31'd0, irq}, 32'd1);
    wr(3'd4, 32'd0);
    rdc(3'd4, 32'd1, "w0_no_effect");
    wr(3'd4, 32'd1);
    rdc(3'd4, 32'd0, "w1c_clear");
    chk("w1c_clear_irq", {31'd0, irq}, 32'd0);

    // COUNT write in the tick cycle where COUNT==0.
    wr(3'd3, 32'd1);
    wr(3'd0, 32'b011);
    rd(3'd3);
    wr(3'd3, 32'd7);
    rdc(3'd3, 32'd7, "count_write_prio");
    rdc(3'd4, 32'd0, "count_write_no_expiry");
    wr(3'd0, 32'd0);

    // Read path with EXPIRED=1 but IRQ_EN=0.
    wr(3'd3, 32'd0);
    wr(3'd0, 32'b001);
    rd(3'd4);
    rdc(3'd4, 32'd1, "masked_expired");
    chk("masked_irq", {31'd0, irq}, 32'd0);
    wr(3'd1, 32'd5); wr(3'd2, 32'hA5A5_0001); wr(3'd3, 32'h0000_1234);
    wr(3'd5, 32'hDEAD_BEEF); wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'h1234_5678);
    rdc(3'd0, 32'd0, "rd_ctrl");
    rdc(3'd1, 32'd5, "rd_prescale");
    rdc(3'd2, 32'hA5A5_0001, "rd_reload");
    rdc(3'd3, 32'h0000_1234, "rd_count");
    rdc(3'd4, 32'd1, "rd_status");
    rdc(3'd5, 32'd0, "rd_unmapped5");
    rdc(3'd6, 32'd0, "rd_unmapped6");
    rdc(3'd7, 32'd0, "rd_unmapped7");
    wr(3'd4, 32'd1);

    // Asynchronous reset in the middle of a count.
    wr(3'd1, 32'd2); wr(3'd3, 32'd3);
    wr(3'd0, 32'b111);
    for (int i = 0; i < 5; i++) rd(3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rdata", reg_q, 32'd0);
    chk("async_reset_irq", {31'd0, irq}, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) rdc(3'(a), 32'd0, "post_reset_reg");
    for (int i = 0; i < 40; i++) rd(3'd4);
    rdc(3'd4, 32'd0, "post_reset_no_expiry");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      case (a)
        3'd1:       d = $urandom_range(0, 3);
        3'd2, 3'd3: d = $urandom_range(0, 6);
        default:    d = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) issue(1'b1, a, d, 1'b0, 32'd0, "rand_wr");
      else issue(1'b0, a, 32'd0, 1'b0, 32'd0, "rand_rd");
    end

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
